// File: rtl/sum_stream_accum_pkg.sv
// Shared types and widths for the sum-stream accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_stream_accum_pkg;

    localparam int ACC_W = 16;
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCUM  = 2'b01,
        OUT_HI = 2'b10,
        OUT_LO = 2'b11
    } state_t;

endpackage

// File: rtl/sum_stream_accum_if.sv
// Stream bundle: 8-bit sum input (sum_in/sum_valid) and byte output (out_data/out_valid/out_ready).
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer stalls out_data; the sum input has no ready.
//   slave  : accumulator side (consumes sums, produces bytes)
//   master : producer/consumer side (drives sums, accepts bytes)
interface sum_stream_accum_if;
    logic [7:0] sum_in;
    logic       sum_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  sum_in,
        input  sum_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output sum_in,
        output sum_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/accum_sat_add.sv
// Next-accumulator adder: acc + zero-extended 8-bit sample, with carry flag.
// Latency: combinational.
// Backpressure: none.
//   Ports: acc (current total), addend (sample), acc_next (next total), carry (17th bit).
//   Macro SUM_STREAM_ACCUM_SAT_EN: when defined, a carry clamps acc_next to all ones.
module accum_sat_add
    import sum_stream_accum_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [7:0]       addend,
    output logic [ACC_W-1:0] acc_next,
    output logic             carry
);

    logic [ACC_W:0] sum_full;

    assign sum_full = {1'b0, acc} + {{(ACC_W + 1 - 8){1'b0}}, addend};
    assign carry    = sum_full[ACC_W];

`ifdef SUM_STREAM_ACCUM_SAT_EN
    // Once clamped at all ones, any nonzero addend carries again, and a zero
    // addend leaves all ones unchanged, so the clamp persists for the frame.
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_next = sum_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_stream_accum.sv
// Accumulates SAMPLES 8-bit sums into a 16-bit total and emits it as two bytes, high first.
// Latency: out_valid rises the cycle after the final sample edge; one byte per cycle minimum.
// Backpressure: out_ready low holds the current byte stable; ena low freezes everything.
//   Ports: clk, rst_n (async, active low), ena, start, bus (sum in / byte out),
//          busy (not IDLE), ovf (sticky 17-bit carry seen this frame).
//   Macro SUM_STREAM_ACCUM_SAT_EN: saturate the total at 16'hFFFF instead of wrapping.
module sum_stream_accum
    import sum_stream_accum_pkg::*;
#(
    parameter int SAMPLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    sum_stream_accum_if.slave   bus,
    output logic                busy,
    output logic                ovf
);

    // Counter compares against the index of the final sample, so it never
    // needs to hold SAMPLES itself (keeps 1023 within CNT_W bits).
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_next;
    logic             carry;

    accum_sat_add u_add (
        .acc      (acc),
        .addend   (bus.sum_in),
        .acc_next (acc_next),
        .carry    (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.sum_valid) begin
                        acc <= acc_next;
                        if (carry) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= OUT_HI;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                OUT_HI: begin
                    if (bus.out_ready) begin
                        state <= OUT_LO;
                    end
                end
                OUT_LO: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state and acc.
    always_comb begin
        bus.out_data  = 8'h00;
        bus.out_valid = 1'b0;
        case (state)
            OUT_HI: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc[15:8];
            end
            OUT_LO: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc[7:0];
            end
            default: begin
                bus.out_valid = 1'b0;
                bus.out_data  = 8'h00;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sum_stream_accum.sv
// Testbench for sum_stream_accum: table-driven frames, hand-written corner sequences,
// and a randomized run against a queue-based frame model.
// Two instances share inputs: SAMPLES=4 for most tests, SAMPLES=300 for overflow.
module tb_sum_stream_accum;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] sum_in;
    logic       sum_valid;
    logic       out_ready;
    logic       busy4, ovf4, busy300, ovf300;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    sum_stream_accum_if if4 ();
    sum_stream_accum_if if300 ();

    assign if4.sum_in      = sum_in;
    assign if4.sum_valid   = sum_valid;
    assign if4.out_ready   = out_ready;
    assign if300.sum_in    = sum_in;
    assign if300.sum_valid = sum_valid;
    assign if300.out_ready = out_ready;

    sum_stream_accum #(.SAMPLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .bus(if4.slave), .busy(busy4), .ovf(ovf4)
    );

    sum_stream_accum #(.SAMPLES(300)) u_dut300 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .bus(if300.slave), .busy(busy300), .ovf(ovf300)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] sums;   // sample i in bits [8*i +: 8], sample 0 first
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Waits (bounded) for out_valid on the chosen instance, captures the byte, transfers it.
    task automatic get_byte(input bit big, output logic [7:0] b);
        int n = 0;
        out_ready = 1'b1;
        while (!(big ? if300.out_valid : if4.out_valid) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("out_valid_timeout", 0, 1);
        b = big ? if300.out_data : if4.out_data;
        tick();
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] v);
        sum_valid = 1'b1;
        sum_in    = v;
        tick();
        sum_valid = 1'b0;
    endtask

    // Frame model: collected samples, then a queue of pending output bytes.
    bit         m_busy;
    bit         m_ovf;
    int         m_samp[$];
    logic [7:0] m_out[$];

    task automatic model_step();
        int total;
        logic [15:0] t16;
        if (!ena) return;
        if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_ovf  = 1'b0;
                m_samp.delete();
            end
        end else if (m_out.size() == 0) begin
            if (sum_valid) begin
                m_samp.push_back(int'(sum_in));
                if (m_samp.size() == 4) begin
                    total = 0;
                    foreach (m_samp[i]) total += m_samp[i];
                    if (total > 65535) m_ovf = 1'b1;
`ifdef SUM_STREAM_ACCUM_SAT_EN
                    t16 = (total > 65535) ? 16'hFFFF : total[15:0];
`else
                    t16 = total[15:0];
`endif
                    m_out.push_back(t16[15:8]);
                    m_out.push_back(t16[7:0]);
                end
            end
        end else if (out_ready) begin
            void'(m_out.pop_front());
            if (m_out.size() == 0) m_busy = 1'b0;
        end
    endtask

    initial begin
        vec_t        vecs[4];
        logic [7:0]  b;
        logic [7:0]  exp_hi, exp_lo;
        logic        exp_vld;
        logic [7:0]  exp_dat;

        vecs[0] = '{32'h281E140A, 8'h00, 8'h64};   // 10,20,30,40
        vecs[1] = '{32'h00000000, 8'h00, 8'h00};
        vecs[2] = '{32'hFFFFFFFF, 8'h03, 8'hFC};   // 4*255 = 1020
        vecs[3] = '{32'h01807F80, 8'h01, 8'h80};   // 128+127+128+1 = 384

        rst_n = 1'b0; ena = 1'b1; start = 1'b0;
        sum_in = 8'h00; sum_valid = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_busy",  {31'd0, busy4},         0);
        chk("rst_valid", {31'd0, if4.out_valid}, 0);
        chk("rst_data",  {24'd0, if4.out_data},  0);
        chk("rst_ovf",   {31'd0, ovf4},          0);
        #10;
        rst_n = 1'b1;
        tick();

        // Table-driven frames (includes basic frame 10,20,30,40).
        for (int v = 0; v < 4; v++) begin
            start_frame();
            chk("tbl_busy_after_start", {31'd0, busy4}, 1);
            for (int i = 0; i < 4; i++) begin
                chk("tbl_no_early_valid", {31'd0, if4.out_valid}, 0);
                feed(vecs[v].sums[8*i +: 8]);
            end
            chk("tbl_valid_after_last", {31'd0, if4.out_valid}, 1);
            get_byte(1'b0, b);
            chk("tbl_hi", {24'd0, b}, {24'd0, vecs[v].hi});
            get_byte(1'b0, b);
            chk("tbl_lo", {24'd0, b}, {24'd0, vecs[v].lo});
            chk("tbl_busy_done", {31'd0, busy4}, 0);
            chk("tbl_ovf", {31'd0, ovf4}, 0);
        end

        // Backpressure: 5 stalled cycles in OUT_HI, then exactly one completion.
        start_frame();
        out_ready = 1'b0;
        feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd40);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", {31'd0, if4.out_valid}, 1);
            chk("bp_data_held",  {24'd0, if4.out_data},  32'h00);
            tick();
        end
        get_byte(1'b0, b);
        chk("bp_hi", {24'd0, b}, 32'h00);
        get_byte(1'b0, b);
        chk("bp_lo", {24'd0, b}, 32'h64);
        tick(); tick();
        chk("bp_once_valid", {31'd0, if4.out_valid}, 0);
        chk("bp_once_busy",  {31'd0, busy4},         0);

        // Gaps and freeze: invalid cycles and ena=0 cycles must not count.
        start_frame();
        feed(8'd10);
        tick();
        feed(8'd20);
        ena = 1'b0; sum_valid = 1'b1; sum_in = 8'd99;
        tick(); tick();
        sum_valid = 1'b0; ena = 1'b1;
        feed(8'd30);
        tick();
        chk("gap_no_extra", {31'd0, if4.out_valid}, 0);
        feed(8'd40);
        chk("gap_valid", {31'd0, if4.out_valid}, 1);
        ena = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("frz_valid_held", {31'd0, if4.out_valid}, 1);
        ena = 1'b1;
        get_byte(1'b0, b);
        chk("gap_hi", {24'd0, b}, 32'h00);
        get_byte(1'b0, b);
        chk("gap_lo", {24'd0, b}, 32'h64);

        // Ignored start during ACCUM and OUT_HI.
        start_frame();
        feed(8'd10);
        start = 1'b1;
        feed(8'd20);
        start = 1'b0;
        feed(8'd30);
        start = 1'b1; out_ready = 1'b0;
        feed(8'd40);
        tick(); tick();
        start = 1'b0;
        chk("ign_hi_held", {24'd0, if4.out_data}, 32'h00);
        get_byte(1'b0, b);
        chk("ign_hi", {24'd0, b}, 32'h00);
        get_byte(1'b0, b);
        chk("ign_lo", {24'd0, b}, 32'h64);

        // Overflow on the 300-sample instance: 300*255 = 76500 = 0x1_2AD4.
        do_reset();
        start_frame();
        for (int i = 0; i < 300; i++) feed(8'hFF);
`ifdef SUM_STREAM_ACCUM_SAT_EN
        exp_hi = 8'hFF; exp_lo = 8'hFF;
`else
        exp_hi = 8'h2A; exp_lo = 8'hD4;
`endif
        chk("ovf_flag", {31'd0, ovf300}, 1);
        get_byte(1'b1, b);
        chk("ovf_hi", {24'd0, b}, {24'd0, exp_hi});
        get_byte(1'b1, b);
        chk("ovf_lo", {24'd0, b}, {24'd0, exp_lo});
        tick(); tick();
        chk("ovf_sticky_idle", {31'd0, ovf300}, 1);
        start_frame();
        chk("ovf_cleared_by_start", {31'd0, ovf300}, 0);

        // Mid-frame asynchronous reset after 2 of 4 samples.
        do_reset();
        start_frame();
        feed(8'd1); feed(8'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, if4.out_valid}, 0);
        chk("mrst_busy",  {31'd0, busy4},         0);
        chk("mrst_ovf",   {31'd0, ovf4},          0);
        chk("mrst_data",  {24'd0, if4.out_data},  0);
        #3;
        rst_n = 1'b1;
        tick();
        start_frame();
        feed(8'd1); feed(8'd1); feed(8'd1); feed(8'd1);
        get_byte(1'b0, b);
        chk("mrst_hi", {24'd0, b}, 32'h00);
        get_byte(1'b0, b);
        chk("mrst_lo", {24'd0, b}, 32'h04);

        // Randomized run against the frame model.
        do_reset();
        m_busy = 1'b0; m_ovf = 1'b0;
        m_samp.delete(); m_out.delete();
        for (int c = 0; c < 3000; c++) begin
            ena       = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            sum_valid = $urandom_range(0, 1);
            sum_in    = 8'($urandom);
            out_ready = $urandom_range(0, 1);
            model_step();
            tick();
            exp_vld = (m_out.size() != 0);
            exp_dat = exp_vld ? m_out[0] : 8'h00;
            chk("rand_cycle",
                {21'd0, busy4, if4.out_valid, ovf4, if4.out_data},
                {21'd0, m_busy, exp_vld, m_ovf, exp_dat});
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
